// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared state encoding, default dividers and width helper for the timebase
package timebase_pkg;

    localparam logic [1:0] ST_PAUSE = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAST  = 2'd2;
    localparam logic [1:0] ST_SYNC  = 2'd3;

    localparam int DEF_SEC_DIV  = 100_000_000;
    localparam int DEF_FAST_DIV = 25_000_000;
    localparam int DEF_SCAN_DIV = 250_000;

    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - modulo counter 0..last with clear, enable and terminal-count flag
module tick_prescaler
    import timebase_pkg::*;
#(
    parameter int LIMIT = 2,
    localparam int W = cnt_width(LIMIT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    // wrap flags the terminal count while enabled; the owner decides whether it becomes a tick
    assign wrap = en && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timebase_scheduler.sv
// rtl/timebase_scheduler.sv - seconds/scan/blink clock enables with pause/run/fast/sync sequencing
module timebase_scheduler
    import timebase_pkg::*;
#(
    parameter int SEC_DIV  = DEF_SEC_DIV,
    parameter int FAST_DIV = DEF_FAST_DIV,
    parameter int SCAN_DIV = DEF_SCAN_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       fast,
    input  logic       sync_req,
    output logic       sync_ack,
    output logic       sec_tick,
    output logic       scan_tick,
    output logic       blink,
    output logic [1:0] state
);

    localparam int SEC_LIMIT = (SEC_DIV > FAST_DIV) ? SEC_DIV : FAST_DIV;
    localparam int SW = cnt_width(SEC_LIMIT);
    localparam int CW = cnt_width(SCAN_DIV);
    localparam int BW = cnt_width(SEC_DIV);

    localparam logic [SW-1:0] SEC_LAST      = SW'(SEC_DIV - 1);
    localparam logic [SW-1:0] FAST_LAST     = SW'(FAST_DIV - 1);
    localparam logic [CW-1:0] SCAN_LAST     = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST    = BW'(SEC_DIV - 1);
    localparam logic [BW-1:0] BLINK_ON_LAST = BW'(SEC_DIV / 2 - 1);

    logic [1:0]    state_nxt;
    logic          sec_en, sec_clr, sec_wrap;
    logic [SW-1:0] sec_last, sec_cnt;
    logic [CW-1:0] scan_cnt;
    logic          scan_wrap;
    logic [BW-1:0] blink_cnt;
    logic          blink_clr, blink_wrap;
    logic          unused_cnt;

    always_comb begin
        state_nxt = ST_PAUSE;
        if (sync_req && (state != ST_SYNC)) begin
            state_nxt = ST_SYNC;
        end else if (fast) begin
            state_nxt = ST_FAST;
        end else if (run) begin
            state_nxt = ST_RUN;
        end
    end

    // Entering or leaving FAST restarts the seconds count so it never exceeds the new limit
    assign sec_en    = (state == ST_RUN) || (state == ST_FAST);
    assign sec_clr   = (state == ST_SYNC) || ((state_nxt == ST_FAST) != (state == ST_FAST));
    assign sec_last  = (state == ST_FAST) ? FAST_LAST : SEC_LAST;
    assign blink_clr = (state == ST_SYNC);

    // raw counts are kept visible for debug only
    assign unused_cnt = ^{sec_cnt, scan_cnt};

    tick_prescaler #(.LIMIT(SEC_LIMIT)) u_sec (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (sec_en),
        .clr  (sec_clr),
        .last (sec_last),
        .cnt  (sec_cnt),
        .wrap (sec_wrap)
    );

    tick_prescaler #(.LIMIT(SCAN_DIV)) u_scan (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .clr  (1'b0),
        .last (SCAN_LAST),
        .cnt  (scan_cnt),
        .wrap (scan_wrap)
    );

    tick_prescaler #(.LIMIT(SEC_DIV)) u_blink (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (1'b1),
        .clr  (blink_clr),
        .last (BLINK_LAST),
        .cnt  (blink_cnt),
        .wrap (blink_wrap)
    );

    // blink is registered from the counter's next value so it stays in step with blink_cnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PAUSE;
            sec_tick  <= 1'b0;
            scan_tick <= 1'b0;
            sync_ack  <= 1'b0;
            blink     <= 1'b1;
        end else begin
            state     <= state_nxt;
            sec_tick  <= sec_wrap && (state_nxt == state);
            scan_tick <= scan_wrap;
            sync_ack  <= (state == ST_SYNC);
            blink     <= (blink_clr || blink_wrap) ? 1'b1 : (blink_cnt < BLINK_ON_LAST);
        end
    end

endmodule

// File: tb/tb_timebase_scheduler.sv
// tb/tb_timebase_scheduler.sv - randomized bench against a cycle-level behavioural timebase model
module tb_timebase_scheduler;

    localparam int SEC = 10;
    localparam int FST = 3;
    localparam int SCN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       fast = 1'b0;
    logic       sync_req = 1'b0;
    logic       sync_ack, sec_tick, scan_tick, blink;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int   m_state, m_sec, m_scan, m_blink;
    logic e_sec_tick, e_scan_tick, e_blink, e_ack;

    always #5 clk = ~clk;

    timebase_scheduler #(.SEC_DIV(SEC), .FAST_DIV(FST), .SCAN_DIV(SCN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .fast     (fast),
        .sync_req (sync_req),
        .sync_ack (sync_ack),
        .sec_tick (sec_tick),
        .scan_tick(scan_tick),
        .blink    (blink),
        .state    (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_sec = 0;
        m_scan = 0;
        m_blink = 0;
        e_sec_tick = 1'b0;
        e_scan_tick = 1'b0;
        e_ack = 1'b0;
        e_blink = 1'b1;
    endtask

    // One rising edge of the timebase: states 0 PAUSE, 1 RUN, 2 FAST, 3 SYNC
    task automatic model_step();
        int nxt, div;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (sync_req && m_state != 3) nxt = 3;
        else if (fast) nxt = 2;
        else if (run) nxt = 1;
        else nxt = 0;
        div = (m_state == 2) ? FST : SEC;
        e_sec_tick = (m_state == 1 || m_state == 2) && (m_sec == div - 1) && (nxt == m_state);
        if (m_state == 3 || ((nxt == 2) != (m_state == 2))) m_sec = 0;
        else if (m_state == 1 || m_state == 2) m_sec = (m_sec + 1) % div;
        e_scan_tick = (m_scan == SCN - 1);
        m_scan = (m_scan + 1) % SCN;
        m_blink = (m_state == 3) ? 0 : (m_blink + 1) % SEC;
        e_blink = (m_blink < SEC / 2);
        e_ack = (m_state == 3);
        m_state = nxt;
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".state"}, state, m_state);
        check({ph, ".sec_tick"}, sec_tick, e_sec_tick);
        check({ph, ".scan_tick"}, scan_tick, e_scan_tick);
        check({ph, ".blink"}, blink, e_blink);
        check({ph, ".sync_ack"}, sync_ack, e_ack);
        check({ph, ".sec_cnt"}, dut.sec_cnt, m_sec);
    endtask

    task automatic cycle(input string ph, input logic r, input logic f, input logic s);
        run = r;
        fast = f;
        sync_req = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all(ph);
    endtask

    initial begin
        int last_s, last_c, n, i;
        model_reset();
        @(negedge clk);
        compare_all("reset");
        cycle("reset_hold", 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        last_s = -1;
        last_c = -1;
        for (int k = 0; k < 40; k++) begin
            cycle("run", 1'b1, 1'b0, 1'b0);
            if (sec_tick) begin
                if (last_s >= 0) check("sec_period", cyc - last_s, SEC);
                last_s = cyc;
            end
            if (scan_tick) begin
                if (last_c >= 0) check("scan_period", cyc - last_c, SCN);
                last_c = cyc;
            end
        end

        for (int k = 0; k < 6; k++) cycle("pre_pause", 1'b1, 1'b0, 1'b0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            cycle("pause", 1'b0, 1'b0, 1'b0);
            n += int'(sec_tick);
        end
        check("pause_ticks", n, 0);
        for (int k = 0; k < 15; k++) cycle("resume", 1'b1, 1'b0, 1'b0);

        last_s = -1;
        for (int k = 0; k < 15; k++) begin
            cycle("fast", 1'b0, 1'b1, 1'b0);
            if (sec_tick) begin
                if (last_s >= 0) check("fast_period", cyc - last_s, FST);
                last_s = cyc;
            end
        end
        cycle("fast_release", 1'b1, 1'b0, 1'b0);
        check("fast_release_cnt", dut.sec_cnt, 0);
        for (int k = 0; k < 15; k++) cycle("after_fast", 1'b1, 1'b0, 1'b0);

        i = 0;
        while (i < 40 && !(m_state == 1 && m_sec == 6)) begin
            cycle("to_sync", 1'b1, 1'b0, 1'b0);
            i++;
        end
        check("reach_cnt6", int'(m_state == 1 && m_sec == 6), 1);
        cycle("sync", 1'b1, 1'b0, 1'b1);
        check("sync_state", state, 3);
        for (int k = 0; k < 15; k++) cycle("after_sync", 1'b1, 1'b0, 1'b0);

        i = 0;
        while (i < 40 && !(m_state == 1 && m_sec == SEC - 1)) begin
            cycle("to_tc", 1'b1, 1'b0, 1'b0);
            i++;
        end
        check("reach_tc", int'(m_state == 1 && m_sec == SEC - 1), 1);
        cycle("sync_tc", 1'b1, 1'b0, 1'b1);
        check("sync_tc_tick", sec_tick, 0);
        n = int'(sync_ack);
        cycle("sync_in_sync", 1'b1, 1'b0, 1'b1);
        n += int'(sync_ack);
        for (int k = 0; k < 4; k++) begin
            cycle("post_double", 1'b1, 1'b0, 1'b0);
            n += int'(sync_ack);
        end
        check("single_ack", n, 1);

        for (int k = 0; k < 1500; k++)
            cycle("rand", ($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 12) == 0);

        for (int k = 0; k < 5; k++) cycle("pre_rst", 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst.state", state, 0);
        check("arst.sec_tick", sec_tick, 0);
        check("arst.scan_tick", scan_tick, 0);
        check("arst.sync_ack", sync_ack, 0);
        check("arst.blink", blink, 1);
        check("arst.sec_cnt", dut.sec_cnt, 0);
        model_reset();
        @(negedge clk);
        cycle("arst_hold", 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 300; k++)
            cycle("rand2", ($urandom % 3) != 0, ($urandom % 5) == 0, ($urandom % 9) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
